data_mem_pipe: RTL and testbench

DATA_MEM_PIPE -- requirements
Module: data_mem_pipe

---
 rtl/data_mem_pipe.sv | 215 +++++++++++++++++++++
 tb/tb_data_mem_pipe.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_pipe.sv
// Byte-addressable data memory with a valid/ready request port and a
// registered response port. After reset the array is cleared by an INIT
// sweep, four bytes per cycle. Loads and stores are big-endian, and
// misaligned, illegal-size or out-of-range requests fault.
module data_mem_pipe #(
  parameter int DEPTH_BYTES = 4096,
  parameter int AW          = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic [7:0]    err_cnt
);

  localparam int IW = $clog2(DEPTH_BYTES);

  localparam logic ST_INIT = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam logic [IW-1:0] LAST_PTR  = IW'(DEPTH_BYTES - 4);
  localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(DEPTH_BYTES);

  logic          state_r;
  logic [IW-1:0] init_ptr_r;
  logic [7:0]    mem_r [DEPTH_BYTES];

  logic          rsp_valid_r;
  logic [31:0]   rsp_rdata_r;
  logic          rsp_err_r;
  logic [7:0]    err_cnt_r;

  logic          req_ready_s;
  logic          accept_s;
  logic          size_bad_s;
  logic          fault_s;
  logic [1:0]    last_off_s;
  logic [AW:0]   end_addr_s;
  logic [IW-1:0] idx0_s;
  logic [IW-1:0] idx1_s;
  logic [IW-1:0] idx2_s;
  logic [IW-1:0] idx3_s;
  logic [31:0]   load_data_s;

  assign req_ready = req_ready_s;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;
  assign err_cnt   = err_cnt_r;

  assign accept_s = req_valid && req_ready_s;

  // Byte lanes of the addressed access; a faulted request never uses them.
  assign idx0_s = req_addr[IW-1:0];
  assign idx1_s = idx0_s + IW'(1'b1);
  assign idx2_s = idx0_s + IW'(2'd2);
  assign idx3_s = idx0_s + IW'(2'd3);

  // Accept a request only in RUN, and only when the response slot frees up this edge.
  always_comb begin
    req_ready_s = 1'b0;
    if (state_r == ST_RUN) begin
      req_ready_s = !rsp_valid_r || rsp_ready;
    end else begin
      req_ready_s = 1'b0;
    end
  end

  // Fault decode: illegal size, misalignment, or last byte past the end (no wrap).
  always_comb begin
    last_off_s = 2'd0;
    size_bad_s = 1'b0;
    case (req_size)
      SZ_WORD: begin
        last_off_s = 2'd3;
        size_bad_s = (req_addr[1:0] != 2'b00);
      end
      SZ_HALF: begin
        last_off_s = 2'd1;
        size_bad_s = req_addr[0];
      end
      SZ_BYTE: begin
        last_off_s = 2'd0;
        size_bad_s = 1'b0;
      end
      default: begin
        last_off_s = 2'd0;
        size_bad_s = 1'b1;
      end
    endcase
    end_addr_s = {1'b0, req_addr} + {{(AW-1){1'b0}}, last_off_s};
    fault_s    = size_bad_s || (end_addr_s >= DEPTH_EXT);
  end

  // Big-endian load assembly with sign or zero extension for sub-word sizes.
  always_comb begin
    load_data_s = 32'h0000_0000;
    case (req_size)
      SZ_WORD: begin
        load_data_s = {mem_r[idx0_s], mem_r[idx1_s], mem_r[idx2_s], mem_r[idx3_s]};
      end
      SZ_HALF: begin
        if (req_signed) begin
          load_data_s = {{16{mem_r[idx0_s][7]}}, mem_r[idx0_s], mem_r[idx1_s]};
        end else begin
          load_data_s = {16'h0000, mem_r[idx0_s], mem_r[idx1_s]};
        end
      end
      SZ_BYTE: begin
        if (req_signed) begin
          load_data_s = {{24{mem_r[idx0_s][7]}}, mem_r[idx0_s]};
        end else begin
          load_data_s = {24'h00_0000, mem_r[idx0_s]};
        end
      end
      default: begin
        load_data_s = 32'h0000_0000;
      end
    endcase
  end

  // INIT sweeps the array four bytes per cycle, then hands over to RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_INIT;
      init_ptr_r <= '0;
    end else begin
      case (state_r)
        ST_INIT: begin
          init_ptr_r <= init_ptr_r + IW'(3'd4);
          if (init_ptr_r == LAST_PTR) begin
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          state_r <= ST_RUN;
        end
        default: begin
          state_r    <= ST_INIT;
          init_ptr_r <= '0;
        end
      endcase
    end
  end

  // Memory array: cleared only by INIT, written by accepted non-faulting stores.
  always_ff @(posedge clk) begin
    if (state_r == ST_INIT) begin
      mem_r[init_ptr_r]               <= 8'h00;
      mem_r[init_ptr_r + IW'(1'b1)]   <= 8'h00;
      mem_r[init_ptr_r + IW'(2'd2)]   <= 8'h00;
      mem_r[init_ptr_r + IW'(2'd3)]   <= 8'h00;
    end else if (accept_s && req_we && !fault_s) begin
      case (req_size)
        SZ_WORD: begin
          mem_r[idx0_s] <= req_wdata[31:24];
          mem_r[idx1_s] <= req_wdata[23:16];
          mem_r[idx2_s] <= req_wdata[15:8];
          mem_r[idx3_s] <= req_wdata[7:0];
        end
        SZ_HALF: begin
          mem_r[idx0_s] <= req_wdata[15:8];
          mem_r[idx1_s] <= req_wdata[7:0];
        end
        SZ_BYTE: begin
          mem_r[idx0_s] <= req_wdata[7:0];
        end
        default: begin
        end
      endcase
    end
  end

  // Response register: loaded on acceptance, held until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
    end else if (accept_s) begin
      rsp_valid_r <= 1'b1;
      rsp_err_r   <= fault_s;
      if (fault_s || req_we) begin
        rsp_rdata_r <= 32'h0000_0000;
      end else begin
        rsp_rdata_r <= load_data_s;
      end
    end else if (rsp_ready) begin
      rsp_valid_r <= 1'b0;
    end
  end

  // Saturating count of faulted requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_r <= 8'h00;
    end else if (accept_s && fault_s && (err_cnt_r != 8'hFF)) begin
      err_cnt_r <= err_cnt_r + 8'h01;
    end
  end

endmodule

// File: tb/tb_data_mem_pipe.sv
// Directed bench for data_mem_pipe with a 64-byte array.
module tb_data_mem_pipe;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_signed;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  err_cnt;

  int n_cmp;
  int n_fail;

  data_mem_pipe #(.DEPTH_BYTES(64), .AW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_signed(req_signed),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request and let one clock edge pass; req_valid stays high.
  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic sgn);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    req_size = size; req_signed = sgn;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    req_size = 2'b00; req_signed = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int lows;
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rsp_rdata got=%h exp=0", rsp_rdata); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_err got=%b exp=0", rsp_err); end
    n_cmp++; if (err_cnt !== 8'h00) begin n_fail++; $display("FAIL rst_err_cnt got=%0d exp=0", err_cnt); end
    rst_n = 1'b1;
    lows = 0;
    while (req_ready !== 1'b1 && lows < 100) begin
      lows++;
      @(posedge clk); #1;
    end
    n_cmp++; if (lows != 16) begin n_fail++; $display("FAIL init_cycles got=%0d exp=16", lows); end
  endtask

  task automatic test_init_load();
    drive(1'b0, 32'h3C, 32'h0, 2'b00, 1'b0);
    n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL init_load_valid got=%b exp=1", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL init_load_rdata got=%h exp=0", rsp_rdata); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL init_load_err got=%b exp=0", rsp_err); end
    idle();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'h08, 32'h11223344, 2'b00, 1'b0);
    n_cmp++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL b2b_store got=%h/%b exp=0/0", rsp_rdata, rsp_err); end
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1 got=%b exp=1", req_ready); end
    drive(1'b0, 32'h09, 32'h0, 2'b10, 1'b1);
    n_cmp++; if (rsp_rdata !== 32'h00000022) begin n_fail++; $display("FAIL b2b_byte got=%h exp=00000022", rsp_rdata); end
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready2 got=%b exp=1", req_ready); end
    drive(1'b0, 32'h0A, 32'h0, 2'b01, 1'b0);
    n_cmp++; if (rsp_rdata !== 32'h00003344) begin n_fail++; $display("FAIL b2b_half got=%h exp=00003344", rsp_rdata); end
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL b2b_half_flags got=%b/%b exp=1/0", rsp_valid, rsp_err); end
    idle();
  endtask

  task automatic test_sign_ext();
    drive(1'b1, 32'h10, 32'hABCDEF80, 2'b10, 1'b0);
    drive(1'b0, 32'h10, 32'h0, 2'b10, 1'b1);
    n_cmp++; if (rsp_rdata !== 32'hFFFFFF80) begin n_fail++; $display("FAIL sext_byte got=%h exp=FFFFFF80", rsp_rdata); end
    drive(1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
    n_cmp++; if (rsp_rdata !== 32'h00000080) begin n_fail++; $display("FAIL zext_byte got=%h exp=00000080", rsp_rdata); end
    drive(1'b0, 32'h10, 32'h0, 2'b01, 1'b1);
    n_cmp++; if (rsp_rdata !== 32'hFFFF8000) begin n_fail++; $display("FAIL sext_half got=%h exp=FFFF8000", rsp_rdata); end
    drive(1'b0, 32'h08, 32'h0, 2'b00, 1'b1);
    n_cmp++; if (rsp_rdata !== 32'h11223344) begin n_fail++; $display("FAIL word_signed got=%h exp=11223344", rsp_rdata); end
    idle();
  endtask

  task automatic test_faults();
    logic [31:0] fa [5];
    logic [1:0]  fs [5];
    fa[0] = 32'h06; fs[0] = 2'b00;
    fa[1] = 32'h03; fs[1] = 2'b01;
    fa[2] = 32'h00; fs[2] = 2'b11;
    fa[3] = 32'h40; fs[3] = 2'b00;
    fa[4] = 32'h3F; fs[4] = 2'b01;
    drive(1'b1, 32'h00, 32'h0BADCAFE, 2'b00, 1'b0);
    drive(1'b1, 32'h04, 32'hCAFEF00D, 2'b00, 1'b0);
    n_cmp++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL fault_setup_err got=%b exp=0", rsp_err); end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, fa[i], 32'h0, fs[i], 1'b0);
      n_cmp++; if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL fault_%0d got=%b/%h exp=1/00000000", i, rsp_err, rsp_rdata); end
    end
    n_cmp++; if (err_cnt !== 8'd5) begin n_fail++; $display("FAIL fault_cnt5 got=%0d exp=5", err_cnt); end
    drive(1'b1, 32'h05, 32'hFFFF1234, 2'b01, 1'b0);
    n_cmp++; if (rsp_err !== 1'b1) begin n_fail++; $display("FAIL fault_store_err got=%b exp=1", rsp_err); end
    n_cmp++; if (err_cnt !== 8'd6) begin n_fail++; $display("FAIL fault_cnt6 got=%0d exp=6", err_cnt); end
    drive(1'b0, 32'h04, 32'h0, 2'b00, 1'b0);
    n_cmp++; if (rsp_rdata !== 32'hCAFEF00D || rsp_err !== 1'b0) begin n_fail++; $display("FAIL fault_nowrite got=%h/%b exp=CAFEF00D/0", rsp_rdata, rsp_err); end
    drive(1'b1, 32'h3F, 32'h0000005A, 2'b10, 1'b0);
    n_cmp++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL edge_store_err got=%b exp=0", rsp_err); end
    drive(1'b0, 32'h3E, 32'h0, 2'b01, 1'b0);
    n_cmp++; if (rsp_rdata !== 32'h0000005A || rsp_err !== 1'b0) begin n_fail++; $display("FAIL edge_half got=%h/%b exp=0000005A/0", rsp_rdata, rsp_err); end
    idle();
  endtask

  task automatic test_err_saturate();
    for (int i = 0; i < 200; i++) drive(1'b0, 32'h00, 32'h0, 2'b11, 1'b0);
    n_cmp++; if (err_cnt !== 8'd206) begin n_fail++; $display("FAIL sat_mid got=%0d exp=206", err_cnt); end
    for (int i = 0; i < 55; i++) drive(1'b0, 32'h00, 32'h0, 2'b11, 1'b0);
    n_cmp++; if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_end got=%0d exp=255", err_cnt); end
    n_cmp++; if (rsp_err !== 1'b1) begin n_fail++; $display("FAIL sat_err got=%b exp=1", rsp_err); end
    idle();
  endtask

  task automatic test_backpressure();
    drive(1'b0, 32'h08, 32'h0, 2'b00, 1'b0);
    rsp_ready = 1'b0;
    req_addr = 32'h0B; req_size = 2'b10; req_signed = 1'b0; req_we = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h11223344 || req_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold_%0d got=%b/%h/%b exp=1/11223344/0", i, rsp_valid, rsp_rdata, req_ready);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got=%b exp=1", req_ready); end
    @(posedge clk); #1;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h00000044) begin n_fail++; $display("FAIL bp_next got=%b/%h exp=1/00000044", rsp_valid, rsp_rdata); end
    idle();
  endtask

  task automatic test_reset_midstream();
    int lows;
    drive(1'b1, 32'h00, 32'hDEADBEEF, 2'b00, 1'b0);
    drive(1'b0, 32'h00, 32'h0, 2'b00, 1'b0);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL mid_pending got=%b/%h exp=1/DEADBEEF", rsp_valid, rsp_rdata); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || rsp_rdata !== 32'h0 || err_cnt !== 8'h00) begin
      n_fail++; $display("FAIL mid_reset got=%b/%b/%h/%0d exp=0/0/00000000/0", rsp_valid, req_ready, rsp_rdata, err_cnt);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    lows = 0;
    while (req_ready !== 1'b1 && lows < 100) begin
      lows++;
      @(posedge clk); #1;
    end
    n_cmp++; if (lows != 16) begin n_fail++; $display("FAIL mid_init_cycles got=%0d exp=16", lows); end
    drive(1'b0, 32'h00, 32'h0, 2'b00, 1'b0);
    n_cmp++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL mid_load0 got=%h/%b exp=00000000/0", rsp_rdata, rsp_err); end
    drive(1'b0, 32'h3C, 32'h0, 2'b00, 1'b0);
    n_cmp++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL mid_load3c got=%h exp=00000000", rsp_rdata); end
    drive(1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
    n_cmp++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL mid_load10 got=%h exp=00000000", rsp_rdata); end
    idle();
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0; rsp_ready = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    req_size = 2'b00; req_signed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_init_load();
    test_back_to_back();
    test_sign_ext();
    test_faults();
    test_err_saturate();
    test_backpressure();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
